// File: rtl/mem_port_arbiter_if.sv
// Requester, RAM and status signals shared by mem_port_arbiter.
// With MEM_ARB_LOCK_EN defined, p0_lock/p1_lock join the bundle.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_done;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_done;
  logic [DATA_W-1:0] p1_rdata;

`ifdef MEM_ARB_LOCK_EN
  logic              p0_lock;
  logic              p1_lock;
`endif

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_rden;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic              busy;
  logic              owner;

  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  p0_lock, p1_lock,
`endif
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_q,
    output p0_gnt, p0_done, p0_rdata,
    output p1_gnt, p1_done, p1_rdata,
    output mem_address, mem_data,
    output mem_rden, mem_wren,
    output busy, owner
  );

  modport master (
`ifdef MEM_ARB_LOCK_EN
    output p0_lock, p1_lock,
`endif
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_q,
    input  p0_gnt, p0_done, p0_rdata,
    input  p1_gnt, p1_done, p1_rdata,
    input  mem_address, mem_data,
    input  mem_rden, mem_wren,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester sequencer for a single-port RAM (IDLE/ISSUE/WAIT/DONE).
// Define MEM_ARB_LOCK_EN to let an owner lock arbitration for bursts.
module mem_port_arbiter #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int RD_LAT        = 1,
  parameter int PRIORITY_MODE = 0
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              rden_q, rden_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic any_req;
  logic win;

`ifdef MEM_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic own_req;
  logic own_lock;

  always_comb begin
    own_req  = owner_q ? bus.p1_req  : bus.p0_req;
    own_lock = owner_q ? bus.p1_lock : bus.p0_lock;
  end
`endif

  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
    if (PRIORITY_MODE != 0) begin
      win = ~bus.p0_req;
    end else if (bus.p0_req && bus.p1_req) begin
      win = ~last_q;
    end else begin
      win = bus.p1_req;
    end
`ifdef MEM_ARB_LOCK_EN
    // A held lock pins the slot to its owner while it keeps asking.
    if (lock_q && own_req) begin
      win = owner_q;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    rden_d   = 1'b0;
    wren_d   = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    lock_d   = lock_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef MEM_ARB_LOCK_EN
        if (lock_q && !own_req) begin
          lock_d = 1'b0;
        end
`endif
        if (any_req) begin
          owner_d = win;
          last_d  = win;
          we_d    = win ? bus.p1_we    : bus.p0_we;
          addr_d  = win ? bus.p1_addr  : bus.p0_addr;
          data_d  = win ? bus.p1_wdata : bus.p0_wdata;
          gnt_d   = win ? 2'b10 : 2'b01;
          wren_d  = we_d;
          rden_d  = ~we_d;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          if (owner_q) begin
            rdata1_d = bus.mem_q;
          end else begin
            rdata0_d = bus.mem_q;
          end
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
`ifdef MEM_ARB_LOCK_EN
        lock_d  = own_lock;
`endif
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      rden_q   <= 1'b0;
      wren_q   <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      addr_q   <= '0;
      data_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      rden_q   <= rden_d;
      wren_q   <= wren_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

  assign bus.p0_gnt      = gnt_q[0];
  assign bus.p1_gnt      = gnt_q[1];
  assign bus.p0_done     = done_q[0];
  assign bus.p1_done     = done_q[1];
  assign bus.p0_rdata    = rdata0_q;
  assign bus.p1_rdata    = rdata1_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_rden    = rden_q;
  assign bus.mem_wren    = wren_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a completion scoreboard.
// Two instances: round-robin/RD_LAT=1 and fixed-priority/RD_LAT=3.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        port;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   p1_act = 0;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ia ();
  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ib ();

  mem_port_arbiter #(
    .ADDR_W(9), .DATA_W(32), .RD_LAT(1), .PRIORITY_MODE(0)
  ) dut_a (
    .clk(clk), .reset(rst_a), .bus(ia)
  );

  mem_port_arbiter #(
    .ADDR_W(9), .DATA_W(32), .RD_LAT(3), .PRIORITY_MODE(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .bus(ib)
  );

  // RAM A: registered address, unregistered q
  logic [31:0] ram_a [512];
  logic [8:0]  ra_a;
  always @(posedge clk) begin
    if (ia.mem_wren) ram_a[ia.mem_address] <= ia.mem_data;
    if (ia.mem_rden | ia.mem_wren) ra_a <= ia.mem_address;
  end
  assign ia.mem_q = ram_a[ra_a];

  // RAM B: read-only pattern, q three cycles after the sampling edge
  function automatic logic [31:0] fb(logic [8:0] a);
    return 32'hB000_0000 | {23'd0, a};
  endfunction
  logic [8:0]  ra_b;
  logic [31:0] s1_b;
  logic [31:0] s2_b;
  always @(posedge clk) begin
    if (ib.mem_rden) ra_b <= ib.mem_address;
    s1_b <= fb(ra_b);
    s2_b <= s1_b;
  end
  assign ib.mem_q = s2_b;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s got %h exp %h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (ia.p1_gnt | ia.p1_done) p1_act++;
    if (ia.p0_done | ia.p1_done) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_a unexpected done got %b%b exp none",
               ia.p1_done, ia.p0_done);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("sb_a_port", 32'(ia.p1_done), 32'(e.port));
        if (e.rd)
          chk("sb_a_rdata",
              e.port ? ia.p1_rdata : ia.p0_rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (ib.p0_done | ib.p1_done) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_b unexpected done got %b%b exp none",
               ib.p1_done, ib.p0_done);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("sb_b_port", 32'(ib.p1_done), 32'(e.port));
        if (e.rd)
          chk("sb_b_rdata",
              e.port ? ib.p1_rdata : ib.p0_rdata, e.data);
      end
    end
  end

  task automatic drv_a(logic p, logic r, logic we,
                       logic [8:0] ad, logic [31:0] d);
    if (p) begin
      ia.p1_req = r; ia.p1_we = we;
      ia.p1_addr = ad; ia.p1_wdata = d;
    end else begin
      ia.p0_req = r; ia.p0_we = we;
      ia.p0_addr = ad; ia.p0_wdata = d;
    end
  endtask

  task automatic drv_b(logic p, logic r, logic we,
                       logic [8:0] ad, logic [31:0] d);
    if (p) begin
      ib.p1_req = r; ib.p1_we = we;
      ib.p1_addr = ad; ib.p1_wdata = d;
    end else begin
      ib.p0_req = r; ib.p0_we = we;
      ib.p0_addr = ad; ib.p0_wdata = d;
    end
  endtask

  task automatic wait_gnt_a(output logic p, output int t);
    int k = 0;
    p = 1'b0;
    t = -1;
    do begin
      @(negedge clk);
      k++;
    end while (!(ia.p0_gnt | ia.p1_gnt) && k < 64);
    chk("gnt_a_seen", 32'(ia.p0_gnt | ia.p1_gnt), 32'd1);
    p = ia.p1_gnt;
    t = cyc;
  endtask

  task automatic wait_gnt_b(output logic p, output int t);
    int k = 0;
    p = 1'b0;
    t = -1;
    do begin
      @(negedge clk);
      k++;
    end while (!(ib.p0_gnt | ib.p1_gnt) && k < 64);
    chk("gnt_b_seen", 32'(ib.p0_gnt | ib.p1_gnt), 32'd1);
    p = ib.p1_gnt;
    t = cyc;
  endtask

  task automatic drain_a();
    for (int k = 0; k < 60 && qa.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_a", 32'(qa.size()), 32'd0);
  endtask

  task automatic drain_b();
    for (int k = 0; k < 60 && qb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_b", 32'(qb.size()), 32'd0);
  endtask

  task automatic access_a(logic p, logic we,
                          logic [8:0] ad, logic [31:0] d);
    logic gp;
    int   t;
    qa.push_back('{p, ~we, d});
    drv_a(p, 1'b1, we, ad, d);
    wait_gnt_a(gp, t);
    chk("acc_a_port", 32'(gp), 32'(p));
    chk("acc_a_addr", 32'(ia.mem_address), 32'(ad));
    drv_a(p, 1'b0, we, ad, d);
    drain_a();
  endtask

  task automatic chk_zero_a(string tag);
    chk({tag, "_ctl"},
        32'({ia.busy, ia.owner, ia.p0_gnt, ia.p1_gnt,
             ia.p0_done, ia.p1_done, ia.mem_rden, ia.mem_wren}),
        32'd0);
    chk({tag, "_addr"}, 32'(ia.mem_address), 32'd0);
    chk({tag, "_data"}, ia.mem_data, 32'd0);
    chk({tag, "_rd0"}, ia.p0_rdata, 32'd0);
    chk({tag, "_rd1"}, ia.p1_rdata, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycles %0d exp finish", cyc);
    $fatal(1, "watchdog");
  end

  logic        gp;
  int          t;
  int          tp;
  logic [31:0] q4;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    drv_a(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    drv_a(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    drv_b(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    drv_b(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
`ifdef MEM_ARB_LOCK_EN
    ia.p0_lock = 1'b0; ia.p1_lock = 1'b0;
    ib.p0_lock = 1'b0; ib.p1_lock = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_zero_a("rst");
    chk("rst_b_ctl", 32'({ib.busy, ib.owner, ib.mem_rden}), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    // p0 write 0x01A, then read it back, with cycle-exact checks
    qa.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
    drv_a(1'b0, 1'b1, 1'b1, 9'h01A, 32'hDEADBEEF);
    @(negedge clk);
    chk("w_t1_gnt", 32'(ia.p0_gnt), 32'd1);
    chk("w_t1_wren", 32'({ia.mem_wren, ia.mem_rden}), 32'b10);
    chk("w_t1_addr", 32'(ia.mem_address), 32'h01A);
    chk("w_t1_data", ia.mem_data, 32'hDEADBEEF);
    chk("w_t1_busy", 32'({ia.busy, ia.owner}), 32'b10);
    drv_a(1'b0, 1'b0, 1'b1, 9'h0, 32'h0);
    @(negedge clk);
    chk("w_t2_done", 32'({ia.p0_done, ia.mem_wren}), 32'b10);
    @(negedge clk);
    chk("w_t3_idle", 32'({ia.busy, ia.p0_done}), 32'd0);
    qa.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
    drv_a(1'b0, 1'b1, 1'b0, 9'h01A, 32'h0);
    @(negedge clk);
    chk("r_t1_rden", 32'({ia.mem_wren, ia.mem_rden}), 32'b01);
    chk("r_t1_gnt", 32'(ia.p0_gnt), 32'd1);
    chk("r_t1_addr", 32'(ia.mem_address), 32'h01A);
    drv_a(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    @(negedge clk);
    chk("r_t2_done", 32'(ia.p0_done), 32'd0);
    @(negedge clk);
    chk("r_t3_done", 32'(ia.p0_done), 32'd1);
    chk("r_t3_rdata", ia.p0_rdata, 32'hDEADBEEF);
    chk("p1_quiet", 32'(p1_act), 32'd0);
    drain_a();

    // writes leave rdata alone
    access_a(1'b0, 1'b1, 9'h010, 32'h1111_0010);
    access_a(1'b1, 1'b1, 9'h020, 32'h2222_0020);
    chk("wr_keeps_rd0", ia.p0_rdata, 32'hDEADBEEF);

    // round-robin from reset: p0 first, alternating, 4-cycle spacing
    rst_a = 1'b0;
    @(negedge clk);
    chk_zero_a("rr_rst");
    rst_a = 1'b1;
    @(negedge clk);
    qa.push_back('{1'b0, 1'b1, 32'h1111_0010});
    qa.push_back('{1'b1, 1'b1, 32'h2222_0020});
    qa.push_back('{1'b0, 1'b1, 32'h1111_0010});
    qa.push_back('{1'b1, 1'b1, 32'h2222_0020});
    drv_a(1'b0, 1'b1, 1'b0, 9'h010, 32'h0);
    drv_a(1'b1, 1'b1, 1'b0, 9'h020, 32'h0);
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt_a(gp, t);
      chk("rr_owner", 32'(gp), 32'(i % 2));
      chk("rr_owner_out", 32'(ia.owner), 32'(i % 2));
      if (i > 0) chk("rr_gap", 32'(t - tp), 32'd4);
      tp = t;
    end
    drv_a(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    drv_a(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    drain_a();

    // reset during WAIT abandons the read and clears every output
    drv_a(1'b1, 1'b1, 1'b0, 9'h01A, 32'h0);
    wait_gnt_a(gp, t);
    drv_a(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    @(negedge clk);
    chk("wait_busy", 32'({ia.busy, ia.owner}), 32'b11);
    #2 rst_a = 1'b0;
    #1 chk_zero_a("mid_rst");
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    access_a(1'b1, 1'b1, 9'h1FF, 32'h1234_5678);
    qa.push_back('{1'b1, 1'b1, 32'h1234_5678});
    drv_a(1'b1, 1'b1, 1'b0, 9'h1FF, 32'h0);
    wait_gnt_a(gp, t);
    chk("top_addr", 32'(ia.mem_address), 32'h1FF);
    chk("top_rden", 32'({ia.mem_rden, gp}), 32'b11);
    drv_a(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    drain_a();
    chk("top_rdata", ia.p1_rdata, 32'h1234_5678);
    chk("top_rd0", ia.p0_rdata, 32'd0);

`ifdef MEM_ARB_LOCK_EN
    // p1 locks for three accesses while p0 waits
    ia.p1_lock = 1'b1;
    qa.push_back('{1'b1, 1'b0, 32'h0});
    qa.push_back('{1'b1, 1'b0, 32'h0});
    qa.push_back('{1'b1, 1'b0, 32'h0});
    qa.push_back('{1'b0, 1'b0, 32'h0});
    drv_a(1'b1, 1'b1, 1'b1, 9'h060, 32'h6);
    for (int i = 0; i < 3; i++) begin
      wait_gnt_a(gp, t);
      chk("lock_p1", 32'(gp), 32'd1);
      if (i == 0) drv_a(1'b0, 1'b1, 1'b1, 9'h061, 32'h7);
    end
    drv_a(1'b1, 1'b0, 1'b1, 9'h060, 32'h6);
    ia.p1_lock = 1'b0;
    wait_gnt_a(gp, t);
    chk("lock_p0", 32'(gp), 32'd0);
    drv_a(1'b0, 1'b0, 1'b1, 9'h061, 32'h7);
    drain_a();
    qa.push_back('{1'b1, 1'b0, 32'h0});
    qa.push_back('{1'b0, 1'b0, 32'h0});
    drv_a(1'b0, 1'b1, 1'b1, 9'h061, 32'h7);
    drv_a(1'b1, 1'b1, 1'b1, 9'h060, 32'h6);
    for (int i = 0; i < 2; i++) begin
      wait_gnt_a(gp, t);
      chk("unlock_alt", 32'(gp), 32'((i + 1) % 2));
    end
    drv_a(1'b0, 1'b0, 1'b1, 9'h0, 32'h0);
    drv_a(1'b1, 1'b0, 1'b1, 9'h0, 32'h0);
    drain_a();
`endif

    // RD_LAT=3: rden in t1, done in t5 with the q of t4
    qb.push_back('{1'b0, 1'b1, fb(9'h033)});
    drv_b(1'b0, 1'b1, 1'b0, 9'h033, 32'h0);
    @(negedge clk);
    chk("l3_t1", 32'({ib.mem_rden, ib.p0_gnt}), 32'b11);
    drv_b(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    @(negedge clk);
    chk("l3_t2_done", 32'(ib.p0_done), 32'd0);
    @(negedge clk);
    chk("l3_t3_done", 32'(ib.p0_done), 32'd0);
    @(negedge clk);
    q4 = ib.mem_q;
    chk("l3_t4_done", 32'(ib.p0_done), 32'd0);
    @(negedge clk);
    chk("l3_t5_done", 32'(ib.p0_done), 32'd1);
    chk("l3_rdata_q4", ib.p0_rdata, q4);
    drain_b();

    // fixed priority: p0 takes five in a row, p1 next once p0 drops
    for (int i = 0; i < 5; i++)
      qb.push_back('{1'b0, 1'b1, fb(9'h040)});
    qb.push_back('{1'b1, 1'b1, fb(9'h050)});
    drv_b(1'b0, 1'b1, 1'b0, 9'h040, 32'h0);
    drv_b(1'b1, 1'b1, 1'b0, 9'h050, 32'h0);
    tp = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt_b(gp, t);
      chk("pm_p0", 32'(gp), 32'd0);
      if (i > 0) chk("pm_gap", 32'(t - tp), 32'd6);
      tp = t;
    end
    drv_b(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    wait_gnt_b(gp, t);
    chk("pm_p1", 32'(gp), 32'd1);
    chk("pm_p1_gap", 32'(t - tp), 32'd6);
    drv_b(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    drain_b();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
